// File: rtl/edram_bank_ctrl.sv
// Request sequencer, refresh scheduler and power gating for one 256x8x32 eDRAM bank.
// Optional reverse body bias during sleep: define EDRAM_BANK_CTRL_RBB_EN.
module edram_bank_ctrl #(
   parameter int REFRESH_INTERVAL = 512,
   parameter int IDLE_TIMEOUT     = 64,
   parameter int WAKE_CYCLES      = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [10:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic [10:0] bank_addr,
   output logic [31:0] din,
   output logic        precharge_en,
   output logic        row_decode_en,
   output logic        col_decode_en,
   output logic        sense_amp_en,
   output logic        write_driver_en,
   output logic        power_gate_en,
   output logic        rbb_en,
   input  logic [31:0] bank_dout,
   output logic        sleep_status
);

   localparam int TW = $clog2(REFRESH_INTERVAL);
   localparam int IW = $clog2(IDLE_TIMEOUT + 1);
   localparam int WW = $clog2(WAKE_CYCLES + 1);
   localparam logic [TW-1:0] TMR_RELOAD = TW'(REFRESH_INTERVAL - 1);
   localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_TIMEOUT);
   localparam logic [WW-1:0] WAKE_LOAD  = WW'(WAKE_CYCLES - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_ROW, S_COL, S_RD, S_WR,
      S_RPRE, S_RROW, S_RSENSE, S_SLEEP, S_WAKE
   } state_t;

   state_t          state_q, state_d;
   logic [10:0]     addr_q, addr_d;
   logic [31:0]     din_q, din_d;
   logic [31:0]     rd_data_q, rd_data_d;
   logic            rd_valid_q, rd_valid_d;
   logic            we_q, we_d;
   logic [7:0]      ref_row_q, ref_row_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic            pend_q, pend_d;
   logic [IW-1:0]   idle_q, idle_d;
   logic [WW-1:0]   wake_q, wake_d;
   logic            ready_q, ready_d;
   logic            pre_q, pre_d;
   logic            row_q, row_d;
   logic            col_q, col_d;
   logic            sense_q, sense_d;
   logic            wr_q, wr_d;
   logic            pg_q, pg_d;
   logic            slp_q, slp_d;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      din_d     = din_q;
      rd_data_d = rd_data_q;
      we_d      = we_q;
      ref_row_d = ref_row_q;
      idle_d    = idle_q;
      wake_d    = wake_q;
      tmr_d     = (tmr_q == '0) ? TMR_RELOAD : tmr_q - 1'b1;
      // A new expiry wins over the clear at the end of a refresh.
      pend_d    = (tmr_q == '0) | (pend_q & (state_q != S_RSENSE));
      unique case (state_q)
         S_IDLE: begin
            if (pend_q) begin
               state_d = S_RPRE;
               addr_d  = {ref_row_q, 3'b000};
            end else if (req_valid) begin
               state_d = S_PRE;
               addr_d  = req_addr;
               din_d   = req_wdata;
               we_d    = req_we;
               idle_d  = '0;
            end else if (idle_q == IDLE_MAX) begin
               state_d = S_SLEEP;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
         S_PRE:    state_d = S_ROW;
         S_ROW:    state_d = S_COL;
         S_COL:    state_d = we_q ? S_WR : S_RD;
         S_RD: begin
            state_d   = S_IDLE;
            rd_data_d = bank_dout;
         end
         S_WR:     state_d = S_IDLE;
         S_RPRE:   state_d = S_RROW;
         S_RROW:   state_d = S_RSENSE;
         S_RSENSE: begin
            state_d   = S_IDLE;
            ref_row_d = ref_row_q + 8'd1;
         end
         S_SLEEP: begin
            if (req_valid | pend_q) begin
               state_d = S_WAKE;
               wake_d  = WAKE_LOAD;
            end
         end
         S_WAKE: begin
            if (wake_q == '0) state_d = S_IDLE;
            else              wake_d  = wake_q - 1'b1;
         end
         default:  state_d = S_IDLE;
      endcase
      rd_valid_d = (state_q == S_RD);
      ready_d    = (state_d == S_IDLE) & ~pend_d;
      pre_d      = (state_d == S_PRE) | (state_d == S_RPRE);
      row_d      = (state_d == S_ROW) | (state_d == S_RROW);
      col_d      = (state_d == S_COL);
      sense_d    = (state_d == S_RD) | (state_d == S_RSENSE);
      wr_d       = (state_d == S_WR);
      pg_d       = (state_d == S_SLEEP);
      slp_d      = (state_d == S_SLEEP) | (state_d == S_WAKE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         din_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         we_q       <= 1'b0;
         ref_row_q  <= '0;
         tmr_q      <= TMR_RELOAD;
         pend_q     <= 1'b0;
         idle_q     <= '0;
         wake_q     <= '0;
         ready_q    <= 1'b1;
         pre_q      <= 1'b0;
         row_q      <= 1'b0;
         col_q      <= 1'b0;
         sense_q    <= 1'b0;
         wr_q       <= 1'b0;
         pg_q       <= 1'b0;
         slp_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         we_q       <= we_d;
         ref_row_q  <= ref_row_d;
         tmr_q      <= tmr_d;
         pend_q     <= pend_d;
         idle_q     <= idle_d;
         wake_q     <= wake_d;
         ready_q    <= ready_d;
         pre_q      <= pre_d;
         row_q      <= row_d;
         col_q      <= col_d;
         sense_q    <= sense_d;
         wr_q       <= wr_d;
         pg_q       <= pg_d;
         slp_q      <= slp_d;
      end
   end

`ifdef EDRAM_BANK_CTRL_RBB_EN
   logic rbb_q, rbb_d;

   always_comb begin
      rbb_d = (state_d == S_SLEEP);
   end

   always_ff @(posedge clk) begin
      if (rst) rbb_q <= 1'b0;
      else     rbb_q <= rbb_d;
   end

   assign rbb_en = rbb_q;
`else
   assign rbb_en = 1'b0;
`endif

   assign req_ready       = ready_q;
   assign rd_valid        = rd_valid_q;
   assign rd_data         = rd_data_q;
   assign bank_addr       = addr_q;
   assign din             = din_q;
   assign precharge_en    = pre_q;
   assign row_decode_en   = row_q;
   assign col_decode_en   = col_q;
   assign sense_amp_en    = sense_q;
   assign write_driver_en = wr_q;
   assign power_gate_en   = pg_q;
   assign sleep_status    = slp_q;

endmodule

// File: tb/tb_edram_bank_ctrl.sv
// Directed bench for edram_bank_ctrl: two instances, one with a bank model
// for access/sleep sequences, one with a short refresh interval.
module tb_edram_bank_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

`ifdef EDRAM_BANK_CTRL_RBB_EN
   localparam logic RBB_EXP = 1'b1;
`else
   localparam logic RBB_EXP = 1'b0;
`endif

   localparam logic [4:0] EN_NONE  = 5'b00000;
   localparam logic [4:0] EN_PRE   = 5'b10000;
   localparam logic [4:0] EN_ROW   = 5'b01000;
   localparam logic [4:0] EN_COL   = 5'b00100;
   localparam logic [4:0] EN_SENSE = 5'b00010;
   localparam logic [4:0] EN_WR    = 5'b00001;

   int n_vec = 0;
   int n_err = 0;

   // main instance: RI=64, IT=8, WC=4
   logic        m_rst, m_req_valid, m_req_ready, m_req_we;
   logic [10:0] m_req_addr, m_bank_addr;
   logic [31:0] m_req_wdata, m_rd_data, m_din, m_bank_dout;
   logic        m_rd_valid, m_pre, m_row, m_col, m_sense, m_wr;
   logic        m_pg, m_rbb, m_sleep;
   logic [4:0]  m_en;
   logic [31:0] m_mem [0:2047];

   assign m_en = {m_pre, m_row, m_col, m_sense, m_wr};
   assign m_bank_dout = m_mem[m_bank_addr];

   always @(posedge clk) begin
      if (m_wr) m_mem[m_bank_addr] <= m_din;
   end

   edram_bank_ctrl #(
      .REFRESH_INTERVAL(64), .IDLE_TIMEOUT(8), .WAKE_CYCLES(4)
   ) u_main (
      .clk(clk), .rst(m_rst),
      .req_valid(m_req_valid), .req_ready(m_req_ready),
      .req_we(m_req_we), .req_addr(m_req_addr), .req_wdata(m_req_wdata),
      .rd_valid(m_rd_valid), .rd_data(m_rd_data),
      .bank_addr(m_bank_addr), .din(m_din),
      .precharge_en(m_pre), .row_decode_en(m_row), .col_decode_en(m_col),
      .sense_amp_en(m_sense), .write_driver_en(m_wr),
      .power_gate_en(m_pg), .rbb_en(m_rbb),
      .bank_dout(m_bank_dout), .sleep_status(m_sleep)
   );

   // refresh instance: RI=16, idle timeout out of reach
   logic        r_rst, r_req_valid, r_req_ready, r_req_we;
   logic [10:0] r_req_addr, r_bank_addr;
   logic [31:0] r_req_wdata, r_rd_data, r_din;
   logic        r_rd_valid, r_pre, r_row, r_col, r_sense, r_wr;
   logic        r_pg, r_rbb, r_sleep;
   logic [4:0]  r_en;

   assign r_en = {r_pre, r_row, r_col, r_sense, r_wr};

   edram_bank_ctrl #(
      .REFRESH_INTERVAL(16), .IDLE_TIMEOUT(10000), .WAKE_CYCLES(4)
   ) u_ref (
      .clk(clk), .rst(r_rst),
      .req_valid(r_req_valid), .req_ready(r_req_ready),
      .req_we(r_req_we), .req_addr(r_req_addr), .req_wdata(r_req_wdata),
      .rd_valid(r_rd_valid), .rd_data(r_rd_data),
      .bank_addr(r_bank_addr), .din(r_din),
      .precharge_en(r_pre), .row_decode_en(r_row), .col_decode_en(r_col),
      .sense_amp_en(r_sense), .write_driver_en(r_wr),
      .power_gate_en(r_pg), .rbb_en(r_rbb),
      .bank_dout(32'h0BAD_F00D), .sleep_status(r_sleep)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int k;
      logic [7:0] row;
      m_rst = 1'b1; m_req_valid = 1'b0; m_req_we = 1'b0;
      m_req_addr = '0; m_req_wdata = '0;
      r_rst = 1'b1; r_req_valid = 1'b0; r_req_we = 1'b0;
      r_req_addr = '0; r_req_wdata = '0;
      tick; tick;

      chk("rst_en", m_en, EN_NONE);
      chk("rst_pg", m_pg, 1'b0);
      chk("rst_rbb", m_rbb, 1'b0);
      chk("rst_rd_valid", m_rd_valid, 1'b0);
      chk("rst_rd_data", m_rd_data, 32'h0);
      chk("rst_bank_addr", m_bank_addr, 11'h0);
      chk("rst_din", m_din, 32'h0);
      chk("rst_ready", m_req_ready, 1'b1);
      chk("rst_sleep", m_sleep, 1'b0);

      // write 0xDEADBEEF to 0x123
      m_rst = 1'b0; m_req_valid = 1'b1; m_req_we = 1'b1;
      m_req_addr = 11'h123; m_req_wdata = 32'hDEADBEEF;
      tick;
      chk("wr_pre", m_en, EN_PRE);
      chk("wr_addr", m_bank_addr, 11'h123);
      chk("wr_din", m_din, 32'hDEADBEEF);
      chk("wr_busy", m_req_ready, 1'b0);
      m_req_valid = 1'b0; m_req_addr = '0; m_req_wdata = '0;
      tick;
      chk("wr_row", m_en, EN_ROW);
      chk("wr_addr_hold", m_bank_addr, 11'h123);
      tick;
      chk("wr_col", m_en, EN_COL);
      tick;
      chk("wr_wr", m_en, EN_WR);
      chk("wr_din_hold", m_din, 32'hDEADBEEF);
      tick;
      chk("wr_end_en", m_en, EN_NONE);
      chk("wr_end_ready", m_req_ready, 1'b1);
      chk("wr_end_rdv", m_rd_valid, 1'b0);

      // read back 0x123
      m_req_valid = 1'b1; m_req_we = 1'b0; m_req_addr = 11'h123;
      tick;
      chk("rd_pre", m_en, EN_PRE);
      m_req_valid = 1'b0;
      tick;
      chk("rd_row", m_en, EN_ROW);
      tick;
      chk("rd_col", m_en, EN_COL);
      tick;
      chk("rd_sense", m_en, EN_SENSE);
      chk("rd_sense_rdv", m_rd_valid, 1'b0);
      tick;
      chk("rd_valid", m_rd_valid, 1'b1);
      chk("rd_data", m_rd_data, 32'hDEADBEEF);
      chk("rd_ready", m_req_ready, 1'b1);
      chk("rd_end_en", m_en, EN_NONE);
      tick;
      chk("rd_valid_pulse", m_rd_valid, 1'b0);
      chk("rd_data_hold", m_rd_data, 32'hDEADBEEF);

      // reset during COL of a write aborts it
      m_req_valid = 1'b1; m_req_we = 1'b1;
      m_req_addr = 11'h123; m_req_wdata = 32'h12345678;
      tick;
      m_req_valid = 1'b0;
      tick; tick;
      chk("abort_col", m_en, EN_COL);
      m_rst = 1'b1;
      tick;
      chk("abort_en", m_en, EN_NONE);
      chk("abort_ready", m_req_ready, 1'b1);
      chk("abort_addr", m_bank_addr, 11'h0);
      chk("abort_rd_data", m_rd_data, 32'h0);
      m_rst = 1'b0; m_req_valid = 1'b1; m_req_we = 1'b0;
      m_req_addr = 11'h123;
      tick;
      m_req_valid = 1'b0;
      repeat (4) tick;
      chk("abort_rdv", m_rd_valid, 1'b1);
      chk("abort_old_data", m_rd_data, 32'hDEADBEEF);

      // idle timeout into sleep, wake by request
      m_rst = 1'b1;
      tick;
      m_rst = 1'b0;
      repeat (8) tick;
      chk("pg_early", m_pg, 1'b0);
      tick;
      chk("pg_sleep", m_pg, 1'b1);
      chk("sleep_status", m_sleep, 1'b1);
      chk("sleep_rbb", m_rbb, RBB_EXP);
      chk("sleep_ready", m_req_ready, 1'b0);
      chk("sleep_en", m_en, EN_NONE);
      tick; tick;
      m_req_valid = 1'b1; m_req_we = 1'b0; m_req_addr = 11'h123;
      tick;
      chk("wake_pg", m_pg, 1'b0);
      chk("wake_rbb", m_rbb, 1'b0);
      chk("wake_status", m_sleep, 1'b1);
      chk("wake_ready", m_req_ready, 1'b0);
      repeat (3) tick;
      chk("wake_ready4", m_req_ready, 1'b0);
      chk("wake_status4", m_sleep, 1'b1);
      tick;
      chk("wake_ready5", m_req_ready, 1'b1);
      chk("wake_status5", m_sleep, 1'b0);
      tick;
      chk("wake_acc", m_en, EN_PRE);
      m_req_valid = 1'b0;
      repeat (4) tick;
      chk("wake_rdv", m_rd_valid, 1'b1);
      chk("wake_rd_data", m_rd_data, 32'hDEADBEEF);

      // refresh expiry while asleep
      k = 0;
      while (m_pg !== 1'b1 && k < 40) begin tick; k++; end
      chk("resleep_cyc", k, 9);
      k = 0;
      while (m_pg !== 1'b0 && k < 60) begin tick; k++; end
      chk("refwake_cyc", k, 35);
      repeat (3) tick;
      chk("refwake_status", m_sleep, 1'b1);
      chk("refwake_en", m_en, EN_NONE);
      tick;
      chk("refwake_idle", m_sleep, 1'b0);
      chk("refwake_ready", m_req_ready, 1'b0);
      tick;
      chk("sref_pre", m_en, EN_PRE);
      chk("sref_addr", m_bank_addr, 11'h0);
      tick;
      chk("sref_row", m_en, EN_ROW);
      tick;
      chk("sref_sense", m_en, EN_SENSE);
      tick;
      chk("sref_end_en", m_en, EN_NONE);
      chk("sref_rdv", m_rd_valid, 1'b0);
      chk("sref_ready", m_req_ready, 1'b1);
      tick;
      chk("sref_resleep", m_pg, 1'b1);

      // periodic refresh, rows 0..255 then wrap
      r_rst = 1'b0;
      for (int i = 0; i < 258; i++) begin
         row = i[7:0];
         k = 0;
         do begin tick; k++; end while (r_pre !== 1'b1 && k < 40);
         chk("ref_period", k, (i == 0) ? 17 : 16);
         chk("ref_row_addr", r_bank_addr, {row, 3'b000});
      end
      tick;
      chk("ref_rrow", r_en, EN_ROW);
      tick;
      chk("ref_rsense", r_en, EN_SENSE);
      tick;
      chk("ref_end_en", r_en, EN_NONE);
      chk("ref_end_ready", r_req_ready, 1'b1);
      chk("ref_no_sleep", r_pg | r_sleep | r_rbb, 1'b0);

      // request in the cycle the timer expires
      r_rst = 1'b1;
      tick;
      r_rst = 1'b0;
      repeat (15) tick;
      r_req_valid = 1'b1; r_req_we = 1'b1;
      r_req_addr = 11'h7FF; r_req_wdata = 32'hA5A5A5A5;
      tick;
      chk("col_acc", r_en, EN_PRE);
      chk("col_addr", r_bank_addr, 11'h7FF);
      chk("col_din", r_din, 32'hA5A5A5A5);
      chk("col_busy", r_req_ready, 1'b0);
      r_req_valid = 1'b0;
      repeat (3) tick;
      chk("col_wr", r_en, EN_WR);
      tick;
      chk("col_idle_en", r_en, EN_NONE);
      chk("col_pend_ready", r_req_ready, 1'b0);
      r_req_valid = 1'b1; r_req_we = 1'b0; r_req_addr = 11'h055;
      tick;
      chk("col_rpre", r_en, EN_PRE);
      chk("col_raddr", r_bank_addr, 11'h000);
      chk("col_rpre_ready", r_req_ready, 1'b0);
      tick;
      chk("col_rrow", r_en, EN_ROW);
      tick;
      chk("col_rsense", r_en, EN_SENSE);
      chk("col_rsense_ready", r_req_ready, 1'b0);
      tick;
      chk("col_ref_end", r_en, EN_NONE);
      chk("col_ref_ready", r_req_ready, 1'b1);
      chk("col_ref_rdv", r_rd_valid, 1'b0);
      chk("col_ref_rd_data", r_rd_data, 32'h0);
      tick;
      chk("col_next_acc", r_en, EN_PRE);
      chk("col_next_addr", r_bank_addr, 11'h055);
      r_req_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/edram_bank_ctrl.md
# edram_bank_ctrl

Sequencing controller for one 2048 x 32 eDRAM memory bank, addressed as 256 rows x 8 columns. It accepts single-word read/write requests over a valid/ready handshake and drives the bank's phase enables in order: precharge, row decode, column decode, then sense or write. It also schedules periodic row refresh and power-gates the bank after an idle timeout. It sits between the bank-select logic and one `memory_bank` instance.

## Interface
- `REFRESH_INTERVAL`, 512: cycles between refresh requests; must be >= 16.
- `IDLE_TIMEOUT`, 64: consecutive quiet IDLE cycles before sleep; must be >= 1.
- `WAKE_CYCLES`, 4: power-up settle cycles before leaving sleep; must be >= 1.

- `clk` in 1: single clock; one clock; reset is synchronous and active-high.
- `rst` in 1: reset; synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 11: {row[7:0], col[2:0]}.
- `req_wdata` in 32: write data.
- `rd_valid` out 1: one-cycle pulse with read data.
- `rd_data` out 32: read data; holds its value until the next read.
- `bank_addr` out 11: address to the bank.
- `din` out 32: write data to the bank.
- `precharge_en`, `row_decode_en`, `col_decode_en`, `sense_amp_en`, `write_driver_en` out 1 each: bank phase enables.
- `power_gate_en` out 1: bank power gated.
- `rbb_en` out 1: reverse body bias.
- `bank_dout` in 32: bank read data.
- `sleep_status` out 1: high in SLEEP and WAKE.

## Operation
- States: IDLE, PRE, ROW, COL, RD, WR, RPRE, RROW, RSENSE, SLEEP, WAKE.
- All outputs are registered.
- Reset values:
  - State is IDLE; all enables and `power_gate_en`, `rbb_en` are 0.
  - `rd_valid` = 0, `rd_data` = 0, `bank_addr` = 0, `din` = 0.
  - Refresh row counter `ref_row` = 0; refresh timer = `REFRESH_INTERVAL-1`; `refresh_pending` = 0; idle counter = 0.
- `req_ready` = (state == IDLE) & !`refresh_pending`.
- On accept:
  - Latch `req_addr` into `bank_addr` and `req_wdata` into `din`.
  - Go to PRE, then ROW, then COL, then RD (read) or WR (write), then IDLE.
  - Exactly one enable is high per state: PRE→`precharge_en`, ROW→`row_decode_en`, COL→`col_decode_en`, RD→`sense_amp_en`, WR→`write_driver_en`.
  - `bank_addr` and `din` are held stable for the entire sequence.
- RD: `rd_data` is captured from `bank_dout` on the clock edge ending RD, and `rd_valid` pulses in the following cycle (first IDLE cycle).
- Refresh timer:
  - Decrements every cycle in every state, including SLEEP.
  - At 0 it reloads to `REFRESH_INTERVAL-1` and sets `refresh_pending`.
- In IDLE with `refresh_pending` set:
  - Go RPRE → RROW → RSENSE → IDLE, with `bank_addr` = {`ref_row`, 3'b000}.
  - The enables are `precharge_en`, `row_decode_en`, `sense_amp_en` respectively.
  - `rd_valid` stays 0.
  - On leaving RSENSE: clear `refresh_pending` and increment `ref_row` (8-bit, wraps 255→0).
- Priority in IDLE: pending refresh over request. A timer expiry in the same cycle a request is accepted does not block that request; the refresh runs after it.
- Idle counter:
  - Counts IDLE cycles with `!req_valid & !refresh_pending`, saturating at `IDLE_TIMEOUT`.
  - Cleared only by an accepted request (refresh does not clear it).
- IDLE → SLEEP when the idle counter equals `IDLE_TIMEOUT` and `!req_valid & !refresh_pending`.
- SLEEP: `power_gate_en` = 1, `rbb_en` per Configuration; remains until `req_valid | refresh_pending`.
- WAKE: `power_gate_en` = 0, `rbb_en` = 0; lasts exactly `WAKE_CYCLES` cycles, then IDLE.
- Wake caused only by refresh: after the refresh the idle counter is still saturated, so the controller re-enters SLEEP on the next IDLE cycle.
- Reset mid-operation aborts the sequence with no write or read completion, and all state returns to reset values.

## Timing
- Read: accept at cycle 0; PRE 1, ROW 2, COL 3, RD 4; `rd_valid` at cycle 5; `req_ready` high again at cycle 5.
- Write: accept at cycle 0; WR at cycle 4; `req_ready` high at cycle 5. Back-to-back throughput is one request per 5 cycles.
- Refresh: 3 busy cycles, plus up to 5 cycles of wait behind an in-flight request.
- Sleep exit: the first request is accepted `WAKE_CYCLES`+1 cycles after `req_valid` rises in SLEEP.

## Configuration
- `EDRAM_BANK_CTRL_RBB_EN`:
  - Defined: `rbb_en` = 1 exactly while in SLEEP.
  - Undefined: `rbb_en` is tied 0; all other behaviour is identical.

## Test plan
- Reset, then write 0xDEADBEEF to addr 0x123, then read 0x123 → enable sequence PRE/ROW/COL/WR then PRE/ROW/COL/RD; `rd_valid` 5 cycles after the read accept with `rd_data` = 0xDEADBEEF.
- `REFRESH_INTERVAL`=16, no requests, `IDLE_TIMEOUT` large → refresh every 16 cycles; `bank_addr` rows 0,1,2…; after 256 refreshes row wraps to 0.
- Request held valid on the cycle the refresh timer expires → request serviced first, then RPRE on the next IDLE cycle with `req_ready` = 0 during the refresh.
- `IDLE_TIMEOUT`=8, `WAKE_CYCLES`=4, no traffic → `power_gate_en` = 1 after 8 idle cycles; assert `req_valid` → `power_gate_en` drops, request accepted 5 cycles later.
- In SLEEP when the refresh timer expires → WAKE (4 cycles), refresh, then back to SLEEP with no external request.
- Assert `rst` during state COL of a write → next cycle all enables 0, `req_ready` = 1; a subsequent read of that address returns the old data; with the macro undefined, `rbb_en` is never 1.
